// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a one-byte holding register
//
// Ports:
//   clk_50M   in   1  system clock, rising edge
//   rst       in   1  synchronous active-high reset
//   tx_valid  in   1  producer offers a byte on tx_data
//   tx_data   in   8  byte to send, sampled only on acceptance
//   tx_ready  out  1  holding register empty
//   tx        out  1  registered serial line, idle high
//   tx_busy   out  1  frame in progress
//   tx_done   out  1  one-cycle pulse after each stop bit completes
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  logic bit_end;
  logic accept;

  assign bit_end = (cnt_q == CNT_LAST);
  // Acceptance needs an empty holding register, so it can never coincide
  // with the FSM draining that register.
  assign accept  = tx_valid && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          done_d = 1'b1;
          // A waiting byte starts immediately so back-to-back frames have no gap.
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase

    // The line is registered, so it follows the state being entered.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign tx_ready = !hold_full_q;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != S_IDLE);
  assign tx_done  = done_q;

endmodule
